burst_drain: RTL and testbench

BURST_DRAIN -- requirements
Module: burst_drain

---
 rtl/burst_drain.sv | 127 ++++++++++++
 tb/tb_burst_drain.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/burst_drain.sv
// Burst drain: pulls whole bursts (or timed-out partial bursts) from an
// upstream FIFO and presents them as a valid/ready stream with m_last
// marking the final beat of each burst.
module burst_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 8,
  parameter int TIMEOUT    = 64,
  parameter int SIZE_WIDTH = $clog2(BURST_LEN*4+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SIZE_WIDTH-1:0] fifo_readable,
  input  logic                  fifo_rd_valid,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [31:0]           burst_cnt
);

  localparam int REM_W = $clog2(BURST_LEN+1);
  localparam logic [SIZE_WIDTH-1:0] BL_SZ    = SIZE_WIDTH'(BURST_LEN);
  localparam logic [REM_W-1:0]      BL_REM   = REM_W'(BURST_LEN);
  localparam logic [REM_W-1:0]      REM_ONE  = REM_W'(1);
  localparam bit                    TMO_EN   = (TIMEOUT > 0);
  localparam logic [31:0]           TMO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  // Clamp a FIFO occupancy to a legal burst length before narrowing it.
  function automatic logic [REM_W-1:0] sat_rem(input logic [SIZE_WIDTH-1:0] n);
    if (n > BL_SZ) return BL_REM;
    return REM_W'(n);
  endfunction

  state_t                state_q, state_d;
  logic [REM_W-1:0]      rem_q, rem_d;
  logic [31:0]           tmo_q, tmo_d;
  logic [31:0]           cnt_q, cnt_d;
  logic                  tmo_run;
  logic                  pop;
  logic                  vld_p1;
  logic                  last_p1;
  logic [DATA_WIDTH-1:0] data_p1;

  assign fifo_rd_ready = (state_q == BURST) && (rem_q != '0) && (!vld_p1 || m_ready);
  assign pop           = fifo_rd_valid && fifo_rd_ready;

  // Stage p0: burst control -- start decision, beat countdown, idle timeout
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    tmo_d   = tmo_q;
    cnt_d   = cnt_q;
    tmo_run = 1'b0;
    case (state_q)
      IDLE: begin
        tmo_run = ((fifo_readable != '0) || fifo_rd_valid) && (fifo_readable < BL_SZ);
        if (fifo_readable >= BL_SZ) begin
          state_d = BURST;
          rem_d   = BL_REM;
          tmo_d   = 32'd0;
        end else if (tmo_run) begin
          if (TMO_EN && (tmo_q == TMO_LAST)) begin
            state_d = BURST;
            tmo_d   = 32'd0;
            rem_d   = (fifo_readable != '0) ? sat_rem(fifo_readable) : REM_ONE;
          end else begin
            tmo_d = tmo_q + 32'd1;
          end
        end else begin
          tmo_d = 32'd0;
        end
      end
      BURST: begin
        if (pop) begin
          rem_d = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            state_d = IDLE;
            cnt_d   = cnt_q + 32'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      tmo_q   <= 32'd0;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stage p1: output beat register, held while the downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      data_p1 <= '0;
    end else if (pop) begin
      vld_p1  <= 1'b1;
      last_p1 <= (rem_q == REM_ONE);
      data_p1 <= fifo_rd_data;
    end else if (vld_p1 && m_ready) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end
  end

  assign m_valid   = vld_p1;
  assign m_last    = last_p1;
  assign m_data    = data_p1;
  assign busy      = (state_q == BURST);
  assign burst_cnt = cnt_q;

endmodule

// File: tb/tb_burst_drain.sv
// Directed bench for burst_drain (DATA_WIDTH=32, BURST_LEN=4, TIMEOUT=8),
// with a second TIMEOUT=0 instance exercised alongside.
module tb_burst_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  fifo_readable;
  logic        fifo_rd_valid;
  logic [31:0] fifo_rd_data;
  logic        fifo_rd_ready;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_last;
  logic        m_ready;
  logic        busy;
  logic [31:0] burst_cnt;

  logic [4:0]  readable2;
  logic        valid2;
  logic        ready2;
  logic        m_valid2;
  logic [31:0] m_data2;
  logic        m_last2;
  logic        busy2;
  logic [31:0] cnt2;
  logic        any_act2 = 1'b0;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  burst_drain #(.DATA_WIDTH(32), .BURST_LEN(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .fifo_readable(fifo_readable), .fifo_rd_valid(fifo_rd_valid),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_ready(fifo_rd_ready), .m_valid(m_valid),
    .m_data(m_data), .m_last(m_last), .m_ready(m_ready), .busy(busy), .burst_cnt(burst_cnt)
  );

  burst_drain #(.DATA_WIDTH(32), .BURST_LEN(4), .TIMEOUT(0)) dut_nt (
    .clk(clk), .rst(rst), .fifo_readable(readable2), .fifo_rd_valid(valid2),
    .fifo_rd_data(32'h5555_0000), .fifo_rd_ready(ready2), .m_valid(m_valid2),
    .m_data(m_data2), .m_last(m_last2), .m_ready(1'b1), .busy(busy2), .burst_cnt(cnt2)
  );

  always @(posedge clk) begin
    if (!rst && (busy2 || ready2 || m_valid2)) any_act2 <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; fifo_readable = '0; fifo_rd_valid = 1'b0; fifo_rd_data = '0; m_ready = 1'b0;
    readable2 = 5'd3; valid2 = 1'b1;
    #2;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", burst_cnt, 0);
    chk("rst_ready", fifo_rd_ready, 0);
    chk("rst_m_data", m_data, 0);
    tick(); tick();
    rst = 1'b0;

    // Full 4-beat burst, data 0x10..0x13
    fifo_readable = 5'd4; fifo_rd_valid = 1'b1; fifo_rd_data = 32'h10; m_ready = 1'b1;
    tick();
    chk("s1_busy", busy, 1);
    chk("s1_ready", fifo_rd_ready, 1);
    chk("s1_no_beat_yet", m_valid, 0);
    fifo_readable = 5'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s1_valid", m_valid, 1);
      chk("s1_data", m_data, 32'h10 + i);
      chk("s1_last", m_last, (i == 3) ? 1 : 0);
      fifo_rd_data = 32'h11 + i;
    end
    chk("s1_cnt", burst_cnt, 1);
    chk("s1_idle", busy, 0);
    fifo_rd_valid = 1'b0;
    tick();
    chk("s1_drain_valid", m_valid, 0);
    chk("s1_drain_last", m_last, 0);

    // Timeout with two entries readable
    fifo_readable = 5'd2; fifo_rd_valid = 1'b1; fifo_rd_data = 32'hA0;
    repeat (7) tick();
    chk("s2_wait_busy", busy, 0);
    chk("s2_wait_ready", fifo_rd_ready, 0);
    tick();
    chk("s2_busy", busy, 1);
    tick();
    chk("s2_b1_data", m_data, 32'hA0);
    chk("s2_b1_last", m_last, 0);
    fifo_rd_data = 32'hA1;
    tick();
    chk("s2_b2_data", m_data, 32'hA1);
    chk("s2_b2_last", m_last, 1);
    chk("s2_cnt", burst_cnt, 2);
    chk("s2_idle", busy, 0);
    fifo_readable = 5'd0; fifo_rd_valid = 1'b0;
    tick();
    chk("s2_drain", m_valid, 0);

    // Timeout with nothing readable but valid data: single beat
    fifo_rd_valid = 1'b1; fifo_rd_data = 32'hB0;
    repeat (7) tick();
    chk("s3_wait_busy", busy, 0);
    tick();
    chk("s3_busy", busy, 1);
    tick();
    chk("s3_data", m_data, 32'hB0);
    chk("s3_last", m_last, 1);
    chk("s3_cnt", burst_cnt, 3);
    fifo_rd_valid = 1'b0;
    tick();
    chk("s3_drain", m_valid, 0);

    // Backpressure for 5 cycles after the first beat
    fifo_readable = 5'd4; fifo_rd_valid = 1'b1; fifo_rd_data = 32'hC0;
    tick();
    fifo_readable = 5'd0;
    tick();
    chk("s4_b0", m_data, 32'hC0);
    fifo_rd_data = 32'hC1; m_ready = 1'b0;
    #1;
    chk("s4_stall_ready", fifo_rd_ready, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s4_hold_data", m_data, 32'hC0);
      chk("s4_hold_valid", m_valid, 1);
      chk("s4_hold_ready", fifo_rd_ready, 0);
    end
    m_ready = 1'b1;
    #1;
    chk("s4_resume_ready", fifo_rd_ready, 1);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("s4_data", m_data, 32'hC0 + i);
      chk("s4_last", m_last, (i == 3) ? 1 : 0);
      fifo_rd_data = 32'hC1 + i;
    end
    chk("s4_cnt", burst_cnt, 4);
    fifo_rd_valid = 1'b0;
    tick();

    // Reset after beat 2 of 4, then a fresh burst
    fifo_readable = 5'd4; fifo_rd_valid = 1'b1; fifo_rd_data = 32'hD0;
    tick();
    fifo_readable = 5'd0;
    tick();
    fifo_rd_data = 32'hD1;
    tick();
    chk("s5_b2", m_data, 32'hD1);
    rst = 1'b1; fifo_rd_valid = 1'b0;
    #1;
    chk("s5_rst_valid", m_valid, 0);
    chk("s5_rst_busy", busy, 0);
    chk("s5_rst_cnt", burst_cnt, 0);
    chk("s5_rst_ready", fifo_rd_ready, 0);
    tick();
    rst = 1'b0;
    fifo_readable = 5'd4; fifo_rd_valid = 1'b1; fifo_rd_data = 32'hE0;
    tick();
    chk("s5_fresh_busy", busy, 1);
    fifo_readable = 5'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s5_data", m_data, 32'hE0 + i);
      chk("s5_last", m_last, (i == 3) ? 1 : 0);
      fifo_rd_data = 32'hE1 + i;
    end
    chk("s5_cnt", burst_cnt, 1);
    fifo_rd_valid = 1'b0;

    // TIMEOUT=0 instance has seen readable=3 all along; run it 1000 more cycles
    repeat (1000) tick();
    chk("s6_busy", busy2, 0);
    chk("s6_never_active", any_act2, 0);
    chk("s6_cnt", cnt2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
